divider_sequential: RTL and testbench

- Iterative unsigned restoring divider; the arithmetic inverse of the combinational W×W→2W multiplier.
- Divides a 2W-bit dividend by a W-bit divisor, producing a W-bit quotient and a W-bit remainder.
- Provides a start/ready/valid handshake, one quotient bit per clock.
- Sits in the FPU datapath for mantissa division and for checking multiplier products (product / B must return A with remainder 0).

---
 rtl/divider_sequential.sv | 101 ++++++++++
 tb/tb_divider_sequential.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_sequential.sv
// rtl/divider_sequential.sv - iterative unsigned restoring divider, 2W/W -> W-bit quotient and remainder
module divider_sequential #(
  parameter int W = 24
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic [2*W-1:0] Data_A_i,
  input  logic [W-1:0]   Data_B_i,
  output logic           ready_o,
  output logic           valid_o,
  output logic [W-1:0]   Data_Q_o,
  output logic [W-1:0]   Data_R_o,
  output logic           div_zero_o,
  output logic           overflow_o
);

  localparam int CW = $clog2(W + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [W-1:0]  divisor;
  logic [W-1:0]  shreg;
  logic [W:0]    prem;
  logic [CW-1:0] count;

  logic [W+2:0]  trial;
  logic          qbit;
  logic [W:0]    prem_next;

  // prem stays below the divisor, so a non-negative trial never reaches bit W+1
  always_comb begin
    trial     = {1'b0, prem, shreg[W-1]} - {3'b000, divisor};
    qbit      = (trial[W+2:W+1] == 2'b00);
    prem_next = qbit ? trial[W:0] : {prem[W-1:0], shreg[W-1]};
  end

  assign ready_o = (state == IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      divisor    <= '0;
      shreg      <= '0;
      prem       <= '0;
      count      <= '0;
      valid_o    <= 1'b0;
      Data_Q_o   <= '0;
      Data_R_o   <= '0;
      div_zero_o <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            divisor    <= Data_B_i;
            shreg      <= Data_A_i[W-1:0];
            prem       <= {1'b0, Data_A_i[2*W-1:W]};
            count      <= '0;
            div_zero_o <= 1'b0;
            overflow_o <= 1'b0;
            if (Data_B_i == '0) begin
              state      <= DONE;
              valid_o    <= 1'b1;
              Data_Q_o   <= '1;
              Data_R_o   <= Data_A_i[W-1:0];
              div_zero_o <= 1'b1;
            end else if (Data_A_i[2*W-1:W] >= Data_B_i) begin
              state      <= DONE;
              valid_o    <= 1'b1;
              Data_Q_o   <= '1;
              Data_R_o   <= '0;
              overflow_o <= 1'b1;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          // quotient bits shift into the low end as dividend bits leave the top
          prem  <= prem_next;
          shreg <= {shreg[W-2:0], qbit};
          count <= count + CW'(1);
          if (count == CW'(W - 1)) begin
            Data_Q_o <= {shreg[W-2:0], qbit};
            Data_R_o <= prem_next[W-1:0];
            valid_o  <= 1'b1;
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_sequential.sv
// tb/tb_divider_sequential.sv - scoreboard bench for divider_sequential at W=8
module tb_divider_sequential;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ov;
  } exp_t;

  logic           clk;
  logic           rst;
  logic           start_i;
  logic [2*W-1:0] Data_A_i;
  logic [W-1:0]   Data_B_i;
  logic           ready_o;
  logic           valid_o;
  logic [W-1:0]   Data_Q_o;
  logic [W-1:0]   Data_R_o;
  logic           div_zero_o;
  logic           overflow_o;

  int   checks = 0;
  int   failures = 0;
  int   valid_cnt = 0;
  int   n;
  exp_t sb[$];

  divider_sequential #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .Data_A_i  (Data_A_i),
    .Data_B_i  (Data_B_i),
    .ready_o   (ready_o),
    .valid_o   (valid_o),
    .Data_Q_o  (Data_Q_o),
    .Data_R_o  (Data_R_o),
    .div_zero_o(div_zero_o),
    .overflow_o(overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [2*W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e = '0;
    if (b == 0) begin
      e.q = '1; e.r = a[W-1:0]; e.dz = 1'b1;
    end else if (a[2*W-1:W] >= b) begin
      e.q = '1; e.r = '0; e.ov = 1'b1;
    end else begin
      e.q = W'(a / {8'd0, b});
      e.r = W'(a % {8'd0, b});
    end
    return e;
  endfunction

  // scoreboard: every valid_o pulse must match the oldest pending expectation
  always @(negedge clk) begin : monitor
    exp_t e;
    if (valid_o) begin
      valid_cnt++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_valid got q=%h r=%h dz=%b ov=%b", Data_Q_o, Data_R_o, div_zero_o, overflow_o);
      end else begin
        e = sb.pop_front();
        if ({Data_Q_o, Data_R_o, div_zero_o, overflow_o} !== e) begin
          failures++;
          $display("FAIL result got q=%h r=%h dz=%b ov=%b expected q=%h r=%h dz=%b ov=%b",
                   Data_Q_o, Data_R_o, div_zero_o, overflow_o, e.q, e.r, e.dz, e.ov);
        end
      end
    end
  end

  task automatic start_op(input logic [2*W-1:0] a, input logic [W-1:0] b, input bit push);
    start_i  = 1'b1;
    Data_A_i = a;
    Data_B_i = b;
    if (push) sb.push_back(model(a, b));
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_valid();
    n = 1;
    while (!valid_o && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start_i = 1'b0; Data_A_i = '0; Data_B_i = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ready_o, valid_o, Data_Q_o, Data_R_o, div_zero_o, overflow_o} !== {1'b1, 1'b0, 16'h0, 2'b00}) begin
      failures++;
      $display("FAIL reset_state got rdy=%b vld=%b q=%h r=%h dz=%b ov=%b", ready_o, valid_o, Data_Q_o, Data_R_o, div_zero_o, overflow_o);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_normal();
    start_op(16'd1000, 8'd7, 1);
    wait_valid();
    checks++;
    if (n !== W + 1) begin failures++; $display("FAIL normal_latency got %0d expected %0d", n, W + 1); end
    checks++;
    if ({Data_Q_o, Data_R_o} !== {8'h8E, 8'd6}) begin
      failures++; $display("FAIL normal_value got q=%h r=%h expected q=8e r=06", Data_Q_o, Data_R_o);
    end
    @(negedge clk);
    checks++;
    if ({valid_o, ready_o} !== 2'b01) begin
      failures++; $display("FAIL valid_one_cycle got vld=%b rdy=%b expected vld=0 rdy=1", valid_o, ready_o);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({Data_Q_o, Data_R_o, div_zero_o, overflow_o} !== {8'h8E, 8'd6, 2'b00}) begin
      failures++; $display("FAIL result_hold got q=%h r=%h expected q=8e r=06", Data_Q_o, Data_R_o);
    end
  endtask

  task automatic test_max();
    start_op(16'hFEFF, 8'hFF, 1);
    wait_valid();
    checks++;
    if (n !== W + 1) begin failures++; $display("FAIL max_latency got %0d expected %0d", n, W + 1); end
    @(negedge clk);
  endtask

  task automatic test_div_zero();
    start_op(16'h1234, 8'h00, 1);
    wait_valid();
    checks++;
    if (n !== 1) begin failures++; $display("FAIL divzero_latency got %0d expected 1", n); end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    start_op(16'h0800, 8'd8, 1);
    wait_valid();
    checks++;
    if (n !== 1) begin failures++; $display("FAIL overflow_latency got %0d expected 1", n); end
    @(negedge clk);
    start_op(16'h07FF, 8'd8, 1);
    wait_valid();
    checks++;
    if (n !== W + 1) begin failures++; $display("FAIL edge_latency got %0d expected %0d", n, W + 1); end
    @(negedge clk);
  endtask

  task automatic test_busy_ignore();
    int v0;
    bit busy_ok;
    v0 = valid_cnt;
    busy_ok = 1'b1;
    start_op(16'd100, 8'd3, 1);
    n = 1;
    while (!valid_o && n < 40) begin
      if (n == 3) begin start_i = 1'b1; Data_A_i = 16'd50; Data_B_i = 8'd5; end
      else if (n == 4) begin start_i = 1'b0; Data_A_i = 16'hFFFF; Data_B_i = 8'd0; end
      if (ready_o !== 1'b0) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== W + 1) begin failures++; $display("FAIL busy_latency got %0d expected %0d", n, W + 1); end
    checks++;
    if (!busy_ok) begin failures++; $display("FAIL busy_ready got ready high during CALC expected low"); end
    repeat (W + 4) @(negedge clk);
    checks++;
    if (valid_cnt - v0 !== 1) begin failures++; $display("FAIL busy_single got %0d valids expected 1", valid_cnt - v0); end
  endtask

  task automatic test_back_to_back();
    int t[3];
    int k;
    int cyc;
    Data_A_i = 16'd100;
    Data_B_i = 8'd3;
    for (int i = 0; i < 3; i++) sb.push_back(model(16'd100, 8'd3));
    start_i = 1'b1;
    k = 0;
    cyc = 0;
    while (k < 3 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (valid_o) begin t[k] = cyc; k++; end
    end
    start_i = 1'b0;
    checks++;
    if (k !== 3) begin failures++; $display("FAIL b2b_count got %0d expected 3", k); end
    else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (t[i] - t[i-1] !== W + 2) begin
          failures++; $display("FAIL b2b_period got %0d expected %0d", t[i] - t[i-1], W + 2);
        end
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_calc();
    int v0;
    start_op(16'd1000, 8'd7, 0);
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({ready_o, valid_o, Data_Q_o, Data_R_o, div_zero_o, overflow_o} !== {1'b1, 1'b0, 16'h0, 2'b00}) begin
      failures++;
      $display("FAIL midcalc_reset got rdy=%b vld=%b q=%h r=%h dz=%b ov=%b", ready_o, valid_o, Data_Q_o, Data_R_o, div_zero_o, overflow_o);
    end
    @(negedge clk);
    rst = 1'b1;
    v0 = valid_cnt;
    repeat (W + 4) @(negedge clk);
    checks++;
    if (valid_cnt !== v0) begin failures++; $display("FAIL abort_no_valid got %0d valids expected 0", valid_cnt - v0); end
    start_op(16'd255, 8'd16, 1);
    wait_valid();
    checks++;
    if ({n, Data_Q_o, Data_R_o} !== {W + 1, 8'd15, 8'd15}) begin
      failures++; $display("FAIL post_reset got lat=%0d q=%h r=%h expected lat=%0d q=0f r=0f", n, Data_Q_o, Data_R_o, W + 1);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_max();
    test_div_zero();
    test_overflow();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_calc();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() !== 0) begin failures++; $display("FAIL pending_results got %0d expected 0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
